// File: rtl/shift_pkg.sv
// Shared encodings and default sizes for the sequential shift unit.
// Build option: SHIFT_SEQ_FAST_EN enables 4-bit steps in the SHIFT state.
package shift_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SHW   = 5;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step (1 bit, or 4 bits in the fast build).
// Build option: SHIFT_SEQ_FAST_EN adds the step4_i port and 4-bit paths.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] work_i,
  input  op_e              op_i,
`ifdef SHIFT_SEQ_FAST_EN
  input  logic             step4_i,
`endif
  output logic [WIDTH-1:0] work_o
);

  logic msb;

  assign msb = work_i[WIDTH-1];

`ifdef SHIFT_SEQ_FAST_EN
  // Shift by 4 or 1 with the fill chosen by the op; pass leaves word alone
  always_comb begin
    work_o = work_i;
    unique case (op_i)
      OP_SLL:
        work_o = step4_i ? {work_i[WIDTH-5:0], 4'b0000}
                         : {work_i[WIDTH-2:0], 1'b0};
      OP_SRL:
        work_o = step4_i ? {4'b0000, work_i[WIDTH-1:4]}
                         : {1'b0, work_i[WIDTH-1:1]};
      OP_SRA:
        work_o = step4_i ? {{4{msb}}, work_i[WIDTH-1:4]}
                         : {msb, work_i[WIDTH-1:1]};
      OP_PASS:
        work_o = work_i;
      default:
        work_o = work_i;
    endcase
  end
`else
  // Shift by one position with the fill chosen by the op
  always_comb begin
    work_o = work_i;
    unique case (op_i)
      OP_SLL:  work_o = {work_i[WIDTH-2:0], 1'b0};
      OP_SRL:  work_o = {1'b0, work_i[WIDTH-1:1]};
      OP_SRA:  work_o = {msb, work_i[WIDTH-1:1]};
      OP_PASS: work_o = work_i;
      default: work_o = work_i;
    endcase
  end
`endif

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle SLL/SRL/SRA unit with start/done handshake.
// Build option: SHIFT_SEQ_FAST_EN shifts by 4 while count >= 4.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHW   = DEF_SHW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Data,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q;
  op_e              op_q;
  op_e              op_in;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [SHW-1:0]   cnt_q;
  logic [SHW-1:0]   cnt_d;
  logic [SHW-1:0]   step_amt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             skip_shift;

  assign op_in      = op_e'(op);
  assign skip_shift = (shamt == '0) || (op_in == OP_PASS);

`ifdef SHIFT_SEQ_FAST_EN
  logic step4;

  // Take a 4-bit stride whenever at least four positions remain
  always_comb begin
    step4    = (cnt_q >= SHW'(4));
    step_amt = step4 ? SHW'(4) : SHW'(1);
  end

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .work_i  (work_q),
    .op_i    (op_q),
    .step4_i (step4),
    .work_o  (work_d)
  );
`else
  assign step_amt = SHW'(1);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .work_i (work_q),
    .op_i   (op_q),
    .work_o (work_d)
  );
`endif

  assign cnt_d = cnt_q - step_amt;

  // Control FSM; result only loads on the edge that enters DONE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      work_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            work_q <= Data;
            cnt_q  <= shamt;
            op_q   <= op_in;
            busy_q <= 1'b1;
            if (skip_shift) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= Data;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_d;
          if (cnt_d == '0) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= work_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: vector table, random ops
// against a plain-arithmetic model, and multi-cycle corner sequences.
module tb_shift_seq_unit;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Data;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  shift_seq_unit dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .op     (op),
    .Data   (Data),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  o;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [31:0] model(input logic [31:0] d,
                                       input logic [4:0] s,
                                       input logic [1:0] o);
    case (o)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return $unsigned($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] s, input logic [1:0] o);
    int n;
    n = int'(s);
    if (o == 2'd3 || n == 0) return 1;
`ifdef SHIFT_SEQ_FAST_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction: latency, hold of result/busy, pulse width
  task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] o, input logic [31:0] er,
                        input int el, input string nm);
    logic [31:0] prev;
    int k;
    bit seen;
    bit bad_busy;
    bit bad_hold;
    @(negedge CLK);
    Data  = d;
    shamt = s;
    op    = o;
    start = 1'b1;
    prev  = result;
    @(posedge CLK);
    #1;
    start = 1'b0;
    Data  = ~d;
    shamt = ~s;
    op    = ~o;
    seen = 0;
    bad_busy = 0;
    bad_hold = 0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge CLK);
      k++;
      if (busy !== 1'b1) bad_busy = 1;
      if (done === 1'b1) seen = 1;
      else if (result !== prev) bad_hold = 1;
    end
    if (!seen) $display("FAIL %s timeout: no done within %0d cycles", nm, k);
    chk({nm, " latency"}, 32'(k), 32'(el));
    chk({nm, " result"}, result, er);
    chk({nm, " busy/hold"}, {30'd0, bad_busy, bad_hold}, 32'd0);
    @(negedge CLK);
    chk({nm, " after done"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  o;
    bit bad;

    tbl[0] = '{32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000};
    tbl[1] = '{32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000};
    tbl[2] = '{32'h8000_0000, 5'd4,  2'd1, 32'h0800_0000};
    tbl[3] = '{32'h0000_0006, 5'd0,  2'd1, 32'h0000_0006};
    tbl[4] = '{32'h0000_0006, 5'd7,  2'd3, 32'h0000_0006};
    tbl[5] = '{32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF};
    tbl[6] = '{32'hDEAD_BEEF, 5'd8,  2'd0, 32'hADBE_EF00};
    tbl[7] = '{32'hDEAD_BEEF, 5'd8,  2'd1, 32'h00DE_ADBE};
    tbl[8] = '{32'hDEAD_BEEF, 5'd8,  2'd2, 32'hFFDE_ADBE};
    tbl[9] = '{32'h7FFF_FFFF, 5'd31, 2'd2, 32'h0000_0000};

    RST   = 1'b0;
    start = 1'b0;
    op    = 2'd0;
    Data  = '0;
    shamt = '0;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].d, tbl[i].s, tbl[i].o, tbl[i].r,
             exp_lat(tbl[i].s, tbl[i].o), $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      o = 2'($urandom_range(0, 3));
      run_op(d, s, o, model(d, s, o), exp_lat(s, o),
             $sformatf("rand%0d", i));
    end

    // Reset asserted in the middle of a long shift
    run_op(32'h5, 5'd1, 2'd0, 32'hA, exp_lat(5'd1, 2'd0), "pre-reset");
    @(negedge CLK);
    Data = 32'h1; shamt = 5'd20; op = 2'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset result", result, 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    RST = 1'b1;
    repeat (25) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    chk("midreset no done", {31'd0, bad}, 32'd0);
    run_op(32'h3, 5'd5, 2'd0, 32'h60, exp_lat(5'd5, 2'd0), "post-reset");

    // start pulses while busy must be ignored
    @(negedge CLK);
    Data = 32'h3; shamt = 5'd2; op = 2'd0; start = 1'b1;
    @(negedge CLK);
    Data = 32'hFF;
    ndone = 0;
    for (int i = 1; i <= 8; i++) begin
      if (done === 1'b1) ndone++;
      if (i == 3) start = 1'b0;
      @(negedge CLK);
    end
    chk("collision done count", 32'(ndone), 32'd1);
    chk("collision result", result, 32'h0000_000C);

    // start held high: accept on each return to IDLE
    @(negedge CLK);
    Data = 32'h1; shamt = 5'd1; op = 2'd0; start = 1'b1;
    ndone = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done !== (i % 3 == 1)) bad = 1;
      if (busy !== (i % 3 != 2)) bad = 1;
      if (done === 1'b1) begin
        chk($sformatf("b2b result%0d", ndone), result,
            (ndone % 2 == 0) ? 32'h2 : 32'h0);
        ndone++;
        op = (op == 2'd0) ? 2'd1 : 2'd0;
      end
    end
    start = 1'b0;
    chk("b2b timing", {31'd0, bad}, 32'd0);
    chk("b2b done count", 32'(ndone), 32'd4);
    repeat (4) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
